lock_code_sender: RTL and testbench
===================================

Name: lock_code_sender

Overview:
- Initiator side of the combination-lock digit interface: collects keypad digits into a 4-entry buffer, then replays them to the lock checker.
- Replay format: one enter_button pulse, then one BCD digit per cycle.
- Waits for the checker's grant/deny, reports the outcome, counts consecutive failures and enforces a timed lockout.
- Sits between the keypad front end and the lock checker.

Parameters:
- N_DIGITS, 4, code length; fixed at 4 to match the checker's four check states.
- MAX_FAILS, 3, consecutive denies that trigger lockout.
- LOCKOUT_CYCLES, 1000, lockout duration in clk cycles.
- RESP_TIMEOUT, 16, cycles after the last digit to wait for grant/deny.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- key_valid  in  1  one-cycle strobe, key_digit valid
- key_digit  in  4  BCD digit 0–9
- key_clear  in  1  discard buffered digits
- key_submit  in  1  request transmission of buffer
- grant  in  1  checker accepts code
- deny  in  1  checker rejects code
- enter_button  out  1  start pulse to checker
- ip_pass  out  4  digit presented to checker
- busy  out  1  high in SEND/WAIT_RESP/LOCKOUT
- digit_count  out  3  digits buffered (0–4)
- result_ok  out  1  one-cycle pulse on grant
- result_fail  out  1  one-cycle pulse on deny or timeout
- timeout  out  1  one-cycle pulse when no response arrives
- locked_out  out  1  high during lockout

Behaviour:
- Reset: all outputs 0, buffer empty, fail counter 0, state COLLECT.
- States: COLLECT, START, SEND, WAIT_RESP, LOCKOUT.

COLLECT:
- Digit capture: key_valid with key_digit ≤ 9 and digit_count < 4 stores the digit at index digit_count and increments digit_count.
- Ignored key_valid: digits > 9, or any key_valid when the buffer is full.
- key_clear: sets digit_count to 0. Priority key_clear > key_submit > key_valid in the same cycle.
- key_submit: with digit_count == 4 → START. With fewer digits it is ignored, and digit_count is unchanged.

START:
- enter_button = 1 for exactly one cycle, ip_pass = 0, then → SEND with index 0.

SEND:
- ip_pass = buf[index] for one cycle each; index 0..3 on 4 consecutive cycles.
- Cycle T = enter_button; digits appear at T+1..T+4, aligned with the checker's check states.
- After index 3 → WAIT_RESP.

WAIT_RESP:
- ip_pass = 0; counter runs from 0.
- grant → result_ok pulse, fail counter cleared, buffer cleared, → COLLECT.
- deny or counter == RESP_TIMEOUT-1 → result_fail pulse (plus timeout pulse when applicable), fail counter increments, buffer cleared.
  - New fail count == MAX_FAILS → LOCKOUT; otherwise → COLLECT.

Early response:
- grant/deny are sampled from the first SEND cycle onward.
- deny during SEND (early mismatch reject): abort remaining digits, ip_pass = 0 next cycle, handle as in WAIT_RESP.
- grant before the last digit is a protocol error and is ignored.
- grant and deny in the same cycle: treated as deny.

LOCKOUT:
- locked_out = 1; key inputs ignored.
- After LOCKOUT_CYCLES cycles: fail counter cleared, → COLLECT, locked_out drops the same cycle.

Other rules:
- key inputs in START/SEND/WAIT_RESP are ignored.
- Synchronous rst mid-operation returns to the reset state on the next edge. No partial pulse; enter_button and ip_pass are 0 from that edge.
- Counter widths: $clog2 of each bound; the fail counter saturates at MAX_FAILS.

Decomposition:
- Shared package lock_pkg: state enum, BCD_MAX = 9, code-length constant N_DIGITS = 4.
- The checker also adopts the code-length constant.
- One natural sub-module: lock_digit_buf (4×4-bit buffer with count, clear, write and indexed read).

Test Plan:
1. Enter 1,5,3,7 then submit → enter_button at T, ip_pass 1,5,3,7 at T+1..T+4; grant at T+5 → result_ok pulse, digit_count = 0, fail count 0.
2. Enter 1,2,3,7, submit; deny asserted at T+2 → digit stream stops, ip_pass = 0 at T+3, result_fail pulse, fail count 1.
3. Three consecutive denied submissions → locked_out = 1 for exactly 1000 cycles; key_valid during lockout leaves digit_count at 0.
4. Submit with no grant/deny → timeout and result_fail pulses 16 cycles after the last digit; busy then falls.
5. key_valid with digit 11, a fifth digit, and submit at 3 digits → all ignored. Same-cycle key_clear + key_submit → buffer cleared, no START.
6. rst asserted at T+2 of a send → next cycle: enter_button = 0, ip_pass = 0, digit_count = 0, busy = 0.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared definitions for the combination-lock digit path (sender and checker).
package lock_pkg;

    localparam int N_DIGITS = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam int CNT_W = $clog2(N_DIGITS + 1);
    localparam int IDX_W = $clog2(N_DIGITS);

    typedef enum logic [2:0] {
        ST_COLLECT,
        ST_START,
        ST_SEND,
        ST_WAIT_RESP,
        ST_LOCKOUT
    } state_e;

    function automatic logic is_bcd(input logic [3:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/lock_code_sender_if.sv
// Keypad, checker and status signals of the lock code sender, bundled with modports.
interface lock_code_sender_if;
    import lock_pkg::*;

    // Handshake: key_valid is a one-cycle strobe qualifying key_digit, with no ready;
    // strobes arriving while the sender cannot take them are dropped. key_clear and
    // key_submit are level-sampled requests. grant/deny are single-cycle responses
    // sampled from the first digit cycle until the response window closes.
    logic             key_valid;
    logic [3:0]       key_digit;
    logic             key_clear;
    logic             key_submit;
    logic             grant;
    logic             deny;
    logic             enter_button;
    logic [3:0]       ip_pass;
    logic             busy;
    logic [CNT_W-1:0] digit_count;
    logic             result_ok;
    logic             result_fail;
    logic             timeout;
    logic             locked_out;
    state_e           state;

    modport master (
        input  key_valid, key_digit, key_clear, key_submit, grant, deny,
        output enter_button, ip_pass, busy, digit_count,
               result_ok, result_fail, timeout, locked_out, state
    );

    modport slave (
        output key_valid, key_digit, key_clear, key_submit, grant, deny,
        input  enter_button, ip_pass, busy, digit_count,
               result_ok, result_fail, timeout, locked_out, state
    );

endinterface

// File: rtl/lock_digit_buf.sv
// Four-entry BCD digit buffer: append at the fill position, clear, indexed read.
module lock_digit_buf
    import lock_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [3:0]       wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [3:0]       rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    logic [3:0] mem [N_DIGITS];

    assign full    = (count == CNT_W'(N_DIGITS));
    assign rd_data = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (wr_en && !full) begin
            count <= count + CNT_W'(1);
        end
    end

    // Contents need no reset: nothing reads them until four digits are written.
    always_ff @(posedge clk) begin
        if (!rst && !clear && wr_en && !full) begin
            mem[count[IDX_W-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/lock_code_sender.sv
// Collects keypad digits, replays them to the lock checker, tracks failures and lockout.
module lock_code_sender
    import lock_pkg::*;
#(
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int RESP_TIMEOUT   = 16
) (
    input logic                clk,
    input logic                rst,
    lock_code_sender_if.master bus
);

    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int LOCK_W = $clog2(LOCKOUT_CYCLES);
    localparam int RESP_W = $clog2(RESP_TIMEOUT);

    state_e             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [FAIL_W-1:0]  fail_cnt, fail_nxt;
    logic [RESP_W-1:0]  resp_cnt;
    logic [LOCK_W-1:0]  lock_cnt;
    logic               buf_clear, buf_wr, buf_full;
    logic [3:0]         rd_data;
    logic [CNT_W-1:0]   digit_count;
    logic               respond_ok, respond_fail;
    logic               enter_button, result_ok, result_fail, timeout;
    logic [3:0]         ip_pass;
    logic               last_idx;

    lock_digit_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .clear   (buf_clear),
        .wr_en   (buf_wr),
        .wr_data (bus.key_digit),
        .rd_idx  (idx),
        .rd_data (rd_data),
        .count   (digit_count),
        .full    (buf_full)
    );

    assign last_idx = (idx == IDX_W'(N_DIGITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_COLLECT;
            idx      <= '0;
            fail_cnt <= '0;
            resp_cnt <= '0;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            fail_cnt <= fail_nxt;
            resp_cnt <= (state == ST_WAIT_RESP) ? resp_cnt + RESP_W'(1) : '0;
            lock_cnt <= (state == ST_LOCKOUT) ? lock_cnt + LOCK_W'(1) : '0;
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        fail_nxt     = fail_cnt;
        buf_clear    = 1'b0;
        buf_wr       = 1'b0;
        enter_button = 1'b0;
        ip_pass      = 4'd0;
        result_ok    = 1'b0;
        result_fail  = 1'b0;
        timeout      = 1'b0;
        respond_ok   = 1'b0;
        respond_fail = 1'b0;

        case (state)
            ST_COLLECT: begin
                if (bus.key_clear) begin
                    buf_clear = 1'b1;
                end else if (bus.key_submit) begin
                    if (buf_full) state_nxt = ST_START;
                end else if (bus.key_valid && is_bcd(bus.key_digit)) begin
                    buf_wr = 1'b1;
                end
            end
            ST_START: begin
                enter_button = 1'b1;
                idx_nxt      = '0;
                state_nxt    = ST_SEND;
            end
            ST_SEND: begin
                ip_pass = rd_data;
                // Deny wins over grant; a grant before the final digit is ignored.
                if (bus.deny) begin
                    respond_fail = 1'b1;
                end else if (last_idx) begin
                    if (bus.grant) respond_ok = 1'b1;
                    else           state_nxt  = ST_WAIT_RESP;
                end else begin
                    idx_nxt = idx + IDX_W'(1);
                end
            end
            ST_WAIT_RESP: begin
                if (bus.deny) begin
                    respond_fail = 1'b1;
                end else if (bus.grant) begin
                    respond_ok = 1'b1;
                end else if (resp_cnt == RESP_W'(RESP_TIMEOUT - 1)) begin
                    respond_fail = 1'b1;
                    timeout      = 1'b1;
                end
            end
            ST_LOCKOUT: begin
                if (lock_cnt == LOCK_W'(LOCKOUT_CYCLES - 1)) begin
                    fail_nxt  = '0;
                    state_nxt = ST_COLLECT;
                end
            end
            default: state_nxt = ST_COLLECT;
        endcase

        if (respond_ok) begin
            result_ok = 1'b1;
            fail_nxt  = '0;
            buf_clear = 1'b1;
            state_nxt = ST_COLLECT;
        end
        if (respond_fail) begin
            result_fail = 1'b1;
            buf_clear   = 1'b1;
            fail_nxt    = (fail_cnt == FAIL_W'(MAX_FAILS)) ? fail_cnt : fail_cnt + FAIL_W'(1);
            state_nxt   = (fail_nxt == FAIL_W'(MAX_FAILS)) ? ST_LOCKOUT : ST_COLLECT;
        end
    end

    assign bus.enter_button = enter_button;
    assign bus.ip_pass      = ip_pass;
    assign bus.busy         = (state == ST_SEND) || (state == ST_WAIT_RESP) || (state == ST_LOCKOUT);
    assign bus.digit_count  = digit_count;
    assign bus.result_ok    = result_ok;
    assign bus.result_fail  = result_fail;
    assign bus.timeout      = timeout;
    assign bus.locked_out   = (state == ST_LOCKOUT);
    assign bus.state        = state;

endmodule

// File: tb/tb_lock_code_sender.sv
// Directed bench for lock_code_sender: capture rules, replay timing, responses, lockout, reset.
module tb_lock_code_sender;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [3:0] exp_q[$];

    lock_code_sender_if bus();

    lock_code_sender dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] d);
        bus.key_valid = 1'b1;
        bus.key_digit = d;
        adv();
        bus.key_valid = 1'b0;
    endtask

    task automatic submit();
        bus.key_submit = 1'b1;
        adv();
        bus.key_submit = 1'b0;
    endtask

    // kind: 0 grant, 1 deny, 2 no response; resp_k is the response cycle relative to enter_button.
    task automatic send_code(input logic [15:0] code, input int kind, input int resp_k,
                             input logic exp_lock);
        int  k;
        bit  done;
        for (int i = 0; i < 4; i++) begin
            press(code[15-4*i -: 4]);
            exp_q.push_back(code[15-4*i -: 4]);
        end
        mid();
        check("count_full", bus.digit_count, 4);
        submit();
        k = 0;
        done = 1'b0;
        while (!done && k < 40) begin
            bus.grant = (kind == 0) && (k == resp_k);
            bus.deny  = (kind == 1) && (k == resp_k);
            mid();
            if (k == 0) begin
                check("enter_button", bus.enter_button, 1);
                check("start_ip_pass", bus.ip_pass, 0);
            end else if (k <= 4) begin
                check("enter_low", bus.enter_button, 0);
                check("ip_pass", bus.ip_pass, exp_q.pop_front());
                check("busy_send", bus.busy, 1);
            end else begin
                check("wait_ip_pass", bus.ip_pass, 0);
                check("busy_wait", bus.busy, 1);
            end
            if (k == resp_k) begin
                check("result_ok", bus.result_ok, kind == 0);
                check("result_fail", bus.result_fail, kind != 0);
                check("timeout", bus.timeout, kind == 2);
                done = 1'b1;
            end else begin
                check("no_result", bus.result_ok | bus.result_fail | bus.timeout, 0);
            end
            adv();
            k++;
        end
        check("resp_seen", done, 1);
        exp_q.delete();
        bus.grant = 1'b0;
        bus.deny  = 1'b0;
        mid();
        check("after_ip_pass", bus.ip_pass, 0);
        check("after_enter", bus.enter_button, 0);
        check("after_count", bus.digit_count, 0);
        check("after_pulse", bus.result_ok | bus.result_fail | bus.timeout, 0);
        check("after_locked", bus.locked_out, exp_lock);
        check("after_busy", bus.busy, exp_lock);
    endtask

    initial begin
        int n;
        rst            = 1'b1;
        bus.key_valid  = 1'b0;
        bus.key_digit  = 4'd0;
        bus.key_clear  = 1'b0;
        bus.key_submit = 1'b0;
        bus.grant      = 1'b0;
        bus.deny       = 1'b0;
        repeat (3) adv();
        rst = 1'b0;
        mid();
        check("rst_enter", bus.enter_button, 0);
        check("rst_ip_pass", bus.ip_pass, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_count", bus.digit_count, 0);
        check("rst_results", bus.result_ok | bus.result_fail | bus.timeout, 0);
        check("rst_locked", bus.locked_out, 0);

        // Input filtering: non-BCD digit, short submit, fifth digit, clear beats submit.
        press(4'd11);
        mid();
        check("non_bcd_ignored", bus.digit_count, 0);
        press(4'd1);
        press(4'd2);
        press(4'd3);
        mid();
        check("three_digits", bus.digit_count, 3);
        submit();
        mid();
        check("short_submit_enter", bus.enter_button, 0);
        check("short_submit_busy", bus.busy, 0);
        check("short_submit_count", bus.digit_count, 3);
        press(4'd4);
        press(4'd5);
        mid();
        check("fifth_ignored", bus.digit_count, 4);
        bus.key_clear  = 1'b1;
        bus.key_submit = 1'b1;
        adv();
        bus.key_clear  = 1'b0;
        bus.key_submit = 1'b0;
        mid();
        check("clear_wins_count", bus.digit_count, 0);
        check("clear_wins_enter", bus.enter_button, 0);

        // Early deny at T+2, then a granted code that clears the fail count.
        send_code(16'h1237, 1, 2, 1'b0);
        send_code(16'h1537, 0, 5, 1'b0);

        // Three denies in a row: lockout only on the third.
        send_code(16'h8642, 1, 3, 1'b0);
        send_code(16'h0999, 1, 6, 1'b0);
        send_code(16'h5050, 1, 1, 1'b1);
        n = 0;
        while (bus.locked_out && n < 1100) begin
            n++;
            adv();
            bus.key_valid = 1'b1;
            bus.key_digit = 4'(n % 10);
            mid();
        end
        bus.key_valid = 1'b0;
        check("lockout_len", n, 1000);
        check("lockout_keys_ignored", bus.digit_count, 0);
        check("lockout_busy_drop", bus.busy, 0);

        // No response: timeout 16 cycles after the last digit.
        send_code(16'h9042, 2, 20, 1'b0);

        // Reset in the middle of a send.
        for (int i = 0; i < 4; i++) press(4'(i + 6));
        submit();
        adv();
        adv();
        rst = 1'b1;
        adv();
        rst = 1'b0;
        mid();
        check("midrst_enter", bus.enter_button, 0);
        check("midrst_ip_pass", bus.ip_pass, 0);
        check("midrst_count", bus.digit_count, 0);
        check("midrst_busy", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
